pwr_request_arbiter: RTL and testbench
======================================

// Module: pwr_request_arbiter
// PURPOSE
// - Decides the single power on/off level (cpu_pwr_on_off) driving the CPU power sequencer from three requesters:
//   BMC pulses, the front-panel button, and fault inputs.
// - Debounces the button, enforces a minimum off time between cycles, and latches faults into a lockout.
// - Sits between BMC/board inputs and the sequencer FSM inside the board CPLD.
// PARAMETERS
// - DEBOUNCE_MS    20    button must be stable this many 1ms ticks before it is accepted
// - LONG_PRESS_MS  4000  debounced hold length (1ms ticks) that forces power off
// - MIN_OFF_100MS  20    minimum 100ms ticks spent in OFF_HOLD before power-on is allowed again
// - CNT_W          13    width of the ms counters; must satisfy 2**CNT_W > LONG_PRESS_MS
// PORTS
// - clock          in   1  system clock
// - reset          in   1  asynchronous, active-low
// - int_1ms_en     in   1  one-clock strobe every 1 ms
// - int_100ms_en   in   1  one-clock strobe every 100 ms
// - bmc_on_req     in   1  one-clock pulse: request power on
// - bmc_off_req    in   1  one-clock pulse: request power off
// - bmc_fault_clr  in   1  one-clock pulse: clear the fault lockout
// - btn_n          in   1  front-panel button, asynchronous, active-low
// - thermal_fault  in   1  level, active-high, synchronous to clock
// - rail_fault     in   1  level, active-high, synchronous to clock
// - cpu_pwr_on_off out  1  level to the sequencer; 1 = power on
// - arb_state      out  2  current state encoding
// - fault_latched  out  1  1 while in FAULT_LOCK
// - req_ack        out  1  one-clock pulse when a request changes the target level
// - req_drop       out  1  one-clock pulse when a request is ignored
// BEHAVIOUR
// - Reset: state=OFF, cpu_pwr_on_off=0, fault_latched=0, req_ack=0, req_drop=0, pending=0, all counters 0.
// - Button path:
//   - btn_n passes through a 2-flop synchronizer, then is inverted to active-high.
//   - Debounce: the synchronized level must hold for DEBOUNCE_MS consecutive int_1ms_en ticks before it updates.
//   - short_press = one-clock pulse on debounced release when held < LONG_PRESS_MS.
//   - long_press = one-clock pulse when the hold count reaches LONG_PRESS_MS; fires once per press.
//   - A release after a long_press produces no short_press.
// - on_req = bmc_on_req | short_press; off_req = bmc_off_req | long_press; fault = thermal_fault | rail_fault.
// - Priority within one cycle: fault > off_req > on_req.
// - State machine (registered outputs; updates 1 clock after the input is sampled):
//   - OFF (00):
//     - on_req -> ON, set cpu_pwr_on_off=1, pulse req_ack.
//     - off_req -> pulse req_drop.
//     - fault -> FAULT_LOCK.
//   - ON (01):
//     - fault -> FAULT_LOCK, clear cpu_pwr_on_off.
//     - off_req -> OFF_HOLD, clear cpu_pwr_on_off, pulse req_ack.
//     - on_req -> pulse req_drop.
//   - OFF_HOLD (10):
//     - On entry, clear the hold counter; it counts int_100ms_en ticks.
//     - An on_req sets pending and pulses req_ack; an off_req clears pending.
//     - At count == MIN_OFF_100MS -> OFF, or straight to ON if pending (pending then clears).
//     - fault -> FAULT_LOCK, clear pending.
//   - FAULT_LOCK (11):
//     - cpu_pwr_on_off=0 and fault_latched=1.
//     - Every on_req and off_req pulses req_drop.
//     - bmc_fault_clr with fault == 0 -> OFF_HOLD with a fresh count.
//     - bmc_fault_clr while fault == 1 is ignored.
// - Counters saturate and never wrap; a press held indefinitely keeps the hold count at LONG_PRESS_MS.
// - A strobe landing in the same cycle as a state entry counts toward the new state.
// - Reset asserted mid-operation returns to the reset values immediately; cpu_pwr_on_off drops asynchronously.
// CONFIGURATION
// - PWR_ARB_AUTO_ON_EN defined:
//   - After reset, the block behaves as if on_req arrived on the first int_100ms_en tick while in OFF.
//   - This is the power-restore-on policy and fires once per reset.
// - PWR_ARB_AUTO_ON_EN undefined: the block stays in OFF until an explicit request.
// STRUCTURE
// - pwr_arb_pkg: localparams for the state encodings OFF/ON/OFF_HOLD/FAULT_LOCK, shared with the sequencer
//   and status registers.
// - Sub-module btn_debounce: synchronizer, debounce counter, short/long press detection; parameters
//   DEBOUNCE_MS, LONG_PRESS_MS, CNT_W.
// TESTING
// 1. bmc_on_req pulse in OFF -> cpu_pwr_on_off=1 and req_ack one cycle later; arb_state=01.
// 2. btn_n low 10ms then high (DEBOUNCE_MS=20) -> no press detected. btn_n low 100ms then released
//    -> short_press; OFF->ON.
// 3. In ON, hold btn_n low 4000ms -> at tick 4000 cpu_pwr_on_off=0, arb_state=10; release produces
//    no short_press.
// 4. bmc_off_req, then bmc_on_req at 500ms -> req_ack, pending=1; ON resumes exactly at 20 x 100ms ticks.
// 5. thermal_fault=1 while ON -> FAULT_LOCK, cpu_pwr_on_off=0. bmc_fault_clr while fault=1 -> ignored.
//    Fault drops, then bmc_fault_clr -> OFF_HOLD.
// 6. bmc_on_req and bmc_off_req in the same cycle while in OFF -> req_drop, stays OFF.
//    With PWR_ARB_AUTO_ON_EN, release from reset -> ON at the first 100ms tick.

Source files
------------

// File: rtl/pwr_arb_pkg.sv
// Shared state encodings for the power request arbiter, the sequencer and the status registers.
package pwr_arb_pkg;

  localparam logic [1:0] ArbStOff       = 2'b00;
  localparam logic [1:0] ArbStOn        = 2'b01;
  localparam logic [1:0] ArbStOffHold   = 2'b10;
  localparam logic [1:0] ArbStFaultLock = 2'b11;

  typedef enum logic [1:0] {
    StOff       = ArbStOff,
    StOn        = ArbStOn,
    StOffHold   = ArbStOffHold,
    StFaultLock = ArbStFaultLock
  } arb_state_e;

endpackage

// File: rtl/pwr_request_arbiter_btn_debounce.sv
// Front-panel button conditioning: 2-flop synchronizer, tick-based debounce and
// short/long press pulse generation.
module btn_debounce
  import pwr_arb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 4000,
  parameter int unsigned CNT_W         = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic int_1ms_en,
  input  logic btn_n,
  output logic short_press,
  output logic long_press
);

  logic [1:0]       sync_q;
  logic             btn_lvl;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;

  // Idle value of the raw button is high, so the synchronizer resets to released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_n};
    end
  end

  assign btn_lvl = ~sync_q[1];

  always_comb begin
    deb_d      = deb_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    short_d    = 1'b0;
    long_d     = 1'b0;

    if (btn_lvl == deb_q) begin
      deb_cnt_d = '0;
    end else if (int_1ms_en) begin
      if (deb_cnt_q >= CNT_W'(DEBOUNCE_MS - 1)) begin
        deb_d     = btn_lvl;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    if (deb_q) begin
      // Saturating at LONG_PRESS_MS makes long_press one-shot and blocks the short press.
      if (int_1ms_en && (hold_cnt_q < CNT_W'(LONG_PRESS_MS))) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        long_d     = (hold_cnt_d == CNT_W'(LONG_PRESS_MS));
      end
      if (!deb_d) begin
        short_d    = (hold_cnt_d < CNT_W'(LONG_PRESS_MS));
        hold_cnt_d = '0;
      end
    end else begin
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      deb_q      <= deb_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      short_q    <= short_d;
      long_q     <= long_d;
    end
  end

  assign short_press = short_q;
  assign long_press  = long_q;

endmodule

// File: rtl/pwr_request_arbiter.sv
// Arbitrates BMC, button and fault requests into the single CPU power on/off level.
// Define PWR_ARB_AUTO_ON_EN for the power-restore-on policy (auto on after reset).
module pwr_request_arbiter
  import pwr_arb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 4000,
  parameter int unsigned MIN_OFF_100MS = 20,
  parameter int unsigned CNT_W         = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       int_1ms_en,
  input  logic       int_100ms_en,
  input  logic       bmc_on_req,
  input  logic       bmc_off_req,
  input  logic       bmc_fault_clr,
  input  logic       btn_n,
  input  logic       thermal_fault,
  input  logic       rail_fault,
  output logic       cpu_pwr_on_off,
  output logic [1:0] arb_state,
  output logic       fault_latched,
  output logic       req_ack,
  output logic       req_drop
);

  arb_state_e       state_q, state_d;
  logic             pwr_q, pwr_d;
  logic             ack_q, ack_d;
  logic             drop_q, drop_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] hold_q, hold_d, hold_inc, hold_entry;
  logic             short_press, long_press;
  logic             on_req, off_req, fault, auto_req;

  btn_debounce #(
    .DEBOUNCE_MS   (DEBOUNCE_MS),
    .LONG_PRESS_MS (LONG_PRESS_MS),
    .CNT_W         (CNT_W)
  ) u_btn_debounce (
    .clock       (clock),
    .reset       (reset),
    .int_1ms_en  (int_1ms_en),
    .btn_n       (btn_n),
    .short_press (short_press),
    .long_press  (long_press)
  );

`ifdef PWR_ARB_AUTO_ON_EN
  logic auto_done_q;

  // Leaving OFF for any reason also consumes the one-shot restore.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      auto_done_q <= 1'b0;
    end else if (auto_req || (state_q != StOff)) begin
      auto_done_q <= 1'b1;
    end
  end

  assign auto_req = (state_q == StOff) && !auto_done_q && int_100ms_en;
`else
  assign auto_req = 1'b0;
`endif

  assign on_req  = bmc_on_req | short_press | auto_req;
  assign off_req = bmc_off_req | long_press;
  assign fault   = thermal_fault | rail_fault;

  // A strobe in the entry cycle already counts toward the off time.
  assign hold_entry = int_100ms_en ? CNT_W'(1) : '0;
  assign hold_inc   = (int_100ms_en && (hold_q < CNT_W'(MIN_OFF_100MS))) ? hold_q + 1'b1 : hold_q;

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    drop_d    = 1'b0;
    pending_d = pending_q;
    hold_d    = '0;

    unique case (state_q)
      StOff: begin
        if (fault) begin
          state_d = StFaultLock;
        end else if (off_req) begin
          drop_d = 1'b1;
        end else if (on_req) begin
          state_d = StOn;
          ack_d   = 1'b1;
        end
      end
      StOn: begin
        if (fault) begin
          state_d = StFaultLock;
        end else if (off_req) begin
          state_d = StOffHold;
          ack_d   = 1'b1;
          hold_d  = hold_entry;
        end else if (on_req) begin
          drop_d = 1'b1;
        end
      end
      StOffHold: begin
        if (fault) begin
          state_d   = StFaultLock;
          pending_d = 1'b0;
        end else begin
          if (off_req) begin
            pending_d = 1'b0;
          end else if (on_req) begin
            pending_d = 1'b1;
            ack_d     = 1'b1;
          end
          hold_d = hold_inc;
          if (hold_inc >= CNT_W'(MIN_OFF_100MS)) begin
            state_d   = pending_d ? StOn : StOff;
            pending_d = 1'b0;
            hold_d    = '0;
          end
        end
      end
      StFaultLock: begin
        drop_d = on_req | off_req;
        if (bmc_fault_clr && !fault) begin
          state_d = StOffHold;
          hold_d  = hold_entry;
        end
      end
      default: state_d = StOff;
    endcase

    pwr_d = (state_d == StOn);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StOff;
      pwr_q     <= 1'b0;
      ack_q     <= 1'b0;
      drop_q    <= 1'b0;
      pending_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      pwr_q     <= pwr_d;
      ack_q     <= ack_d;
      drop_q    <= drop_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end

  assign cpu_pwr_on_off = pwr_q;
  assign arb_state      = state_q;
  assign fault_latched  = (state_q == StFaultLock);
  assign req_ack        = ack_q;
  assign req_drop       = drop_q;

endmodule

// File: tb/tb_pwr_request_arbiter.sv
// Directed bench for pwr_request_arbiter; inputs driven on the falling edge, outputs checked there.
module tb_pwr_request_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       int_1ms_en, int_100ms_en;
  logic       bmc_on_req, bmc_off_req, bmc_fault_clr;
  logic       btn_n, thermal_fault, rail_fault;
  logic       cpu_pwr_on_off;
  logic [1:0] arb_state;
  logic       fault_latched, req_ack, req_drop;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  pwr_request_arbiter u_dut (
    .clock          (clock),
    .reset          (reset),
    .int_1ms_en     (int_1ms_en),
    .int_100ms_en   (int_100ms_en),
    .bmc_on_req     (bmc_on_req),
    .bmc_off_req    (bmc_off_req),
    .bmc_fault_clr  (bmc_fault_clr),
    .btn_n          (btn_n),
    .thermal_fault  (thermal_fault),
    .rail_fault     (rail_fault),
    .cpu_pwr_on_off (cpu_pwr_on_off),
    .arb_state      (arb_state),
    .fault_latched  (fault_latched),
    .req_ack        (req_ack),
    .req_drop       (req_drop)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 0 = on, 1 = off, 2 = fault clear, 3 = on+off together
  task automatic pulse(input int which);
    @(negedge clock);
    bmc_on_req    = (which == 0) || (which == 3);
    bmc_off_req   = (which == 1) || (which == 3);
    bmc_fault_clr = (which == 2);
    @(negedge clock);
    bmc_on_req    = 1'b0;
    bmc_off_req   = 1'b0;
    bmc_fault_clr = 1'b0;
  endtask

  task automatic tick_ms(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock) int_1ms_en = 1'b1;
      @(negedge clock) int_1ms_en = 1'b0;
    end
  endtask

  task automatic tick_100(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock) int_100ms_en = 1'b1;
      @(negedge clock) int_100ms_en = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    {int_1ms_en, int_100ms_en, bmc_on_req, bmc_off_req, bmc_fault_clr} = '0;
    {thermal_fault, rail_fault} = '0;
    btn_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_state", 32'(arb_state), 32'd0);
    check_eq("rst_pwr", 32'(cpu_pwr_on_off), 32'd0);
    check_eq("rst_fault", 32'(fault_latched), 32'd0);
    check_eq("rst_ack", 32'(req_ack), 32'd0);
    check_eq("rst_drop", 32'(req_drop), 32'd0);
    reset = 1'b1;

    // BMC on/off basics
    pulse(0);
    check_eq("on_ack", 32'(req_ack), 32'd1);
    check_eq("on_pwr", 32'(cpu_pwr_on_off), 32'd1);
    check_eq("on_state", 32'(arb_state), 32'd1);
    pulse(0);
    check_eq("on_in_on_drop", 32'(req_drop), 32'd1);
    check_eq("on_in_on_ack", 32'(req_ack), 32'd0);
    pulse(1);
    check_eq("off_ack", 32'(req_ack), 32'd1);
    check_eq("off_pwr", 32'(cpu_pwr_on_off), 32'd0);
    check_eq("off_state", 32'(arb_state), 32'd2);
    tick_100(20);
    check_eq("hold_expire_off", 32'(arb_state), 32'd0);
    pulse(1);
    check_eq("off_in_off_drop", 32'(req_drop), 32'd1);

    // Button glitch, then short press
    btn_n = 1'b0;
    tick_ms(10);
    btn_n = 1'b1;
    tick_ms(40);
    check_eq("glitch_no_press", 32'(arb_state), 32'd0);
    btn_n = 1'b0;
    tick_ms(100);
    btn_n = 1'b1;
    tick_ms(10);
    check_eq("short_before_deb", 32'(arb_state), 32'd0);
    tick_ms(20);
    check_eq("short_on_state", 32'(arb_state), 32'd1);
    check_eq("short_on_pwr", 32'(cpu_pwr_on_off), 32'd1);

    // Long press forces off; its release must not queue an on
    btn_n = 1'b0;
    tick_ms(4010);
    check_eq("long_before_pwr", 32'(cpu_pwr_on_off), 32'd1);
    tick_ms(20);
    check_eq("long_pwr", 32'(cpu_pwr_on_off), 32'd0);
    check_eq("long_state", 32'(arb_state), 32'd2);
    btn_n = 1'b1;
    tick_ms(40);
    tick_100(20);
    check_eq("long_release_no_short", 32'(arb_state), 32'd0);

    // Pending on during OFF_HOLD resumes exactly at the 20th tick
    pulse(0);
    pulse(1);
    tick_100(5);
    pulse(0);
    check_eq("pending_ack", 32'(req_ack), 32'd1);
    check_eq("pending_hold", 32'(arb_state), 32'd2);
    tick_100(14);
    check_eq("pending_tick19", 32'(arb_state), 32'd2);
    tick_100(1);
    check_eq("pending_tick20", 32'(arb_state), 32'd1);
    check_eq("pending_pwr", 32'(cpu_pwr_on_off), 32'd1);

    // Thermal fault lockout
    @(negedge clock) thermal_fault = 1'b1;
    @(negedge clock);
    check_eq("fault_state", 32'(arb_state), 32'd3);
    check_eq("fault_pwr", 32'(cpu_pwr_on_off), 32'd0);
    check_eq("fault_latched", 32'(fault_latched), 32'd1);
    pulse(2);
    check_eq("clr_while_fault", 32'(arb_state), 32'd3);
    thermal_fault = 1'b0;
    pulse(0);
    check_eq("lock_on_drop", 32'(req_drop), 32'd1);
    pulse(2);
    check_eq("clr_state", 32'(arb_state), 32'd2);
    check_eq("clr_unlatched", 32'(fault_latched), 32'd0);
    tick_100(20);
    check_eq("clr_hold_off", 32'(arb_state), 32'd0);

    // Rail fault from OFF; clear with a coincident strobe counts as tick 1
    @(negedge clock) rail_fault = 1'b1;
    @(negedge clock) rail_fault = 1'b0;
    check_eq("rail_state", 32'(arb_state), 32'd3);
    bmc_fault_clr = 1'b1;
    int_100ms_en  = 1'b1;
    @(negedge clock);
    bmc_fault_clr = 1'b0;
    int_100ms_en  = 1'b0;
    tick_100(18);
    check_eq("entry_tick_19", 32'(arb_state), 32'd2);
    tick_100(1);
    check_eq("entry_tick_20", 32'(arb_state), 32'd0);

    // Simultaneous on and off in OFF
    pulse(3);
    check_eq("both_drop", 32'(req_drop), 32'd1);
    check_eq("both_no_ack", 32'(req_ack), 32'd0);
    check_eq("both_state", 32'(arb_state), 32'd0);

    // Asynchronous reset drops power immediately
    pulse(0);
    check_eq("pre_reset_pwr", 32'(cpu_pwr_on_off), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_pwr", 32'(cpu_pwr_on_off), 32'd0);
    check_eq("async_rst_state", 32'(arb_state), 32'd0);
    @(negedge clock) reset = 1'b1;

    tick_100(1);
`ifdef PWR_ARB_AUTO_ON_EN
    check_eq("auto_on_state", 32'(arb_state), 32'd1);
    check_eq("auto_on_pwr", 32'(cpu_pwr_on_off), 32'd1);
`else
    check_eq("no_auto_state", 32'(arb_state), 32'd0);
    check_eq("no_auto_pwr", 32'(cpu_pwr_on_off), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
